// File: rtl/mb_reduce_engine_if.sv
// Macroblock reduce engine bus bundle.
// Groups the memory-interface request/response signals, the frame control
// inputs and the reduced-byte output stream.
//   master : the reduce engine (drives inq_addr/inqury_update/frame_complete,
//            res_data/res_valid and busy)
//   slave  : the environment (memory interface, frame source, byte sink)
interface mb_reduce_engine_if;
    logic        data_ready;
    logic [31:0] MB_flat;
    logic        MB_ready;
    logic [14:0] inq_addr;
    logic        inqury_update;
    logic        frame_complete;
    logic        mode;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_full;
    logic        busy;

    modport master (
        input  data_ready, MB_flat, MB_ready, mode, res_full,
        output inq_addr, inqury_update, frame_complete, res_data, res_valid, busy
    );

    modport slave (
        output data_ready, MB_flat, MB_ready, mode, res_full,
        input  inq_addr, inqury_update, frame_complete, res_data, res_valid, busy
    );
endinterface

// File: rtl/mb_reduce_engine.sv
// Macroblock reduce engine.
// Walks a 128x128 grid of 2x2 macroblocks in raster order, requests each one
// from the memory interface, reduces the four pixels to one byte (rounded
// average or maximum) and hands the byte to a downstream sink.
// Ports:
//   clk   : rising-edge clock shared with the memory interface
//   rst_n : synchronous active-low reset
//   bus   : mb_reduce_engine_if.master
//           data_ready     in  frame written; a rising edge starts a frame
//           MB_flat        in  {p3,p2,p1,p0}, valid when MB_ready rises
//           MB_ready       in  memory idle / data valid
//           mode           in  0 = rounded average, 1 = maximum
//           res_full       in  sink cannot accept
//           inq_addr       out {1'b0,row[6:0],col[6:0]}
//           inqury_update  out one-cycle read request
//           frame_complete out last request issued / frame finished
//           res_data       out reduced pixel
//           res_valid      out res_data valid
//           busy           out engine not idle
module mb_reduce_engine (
    input  logic               clk,
    input  logic               rst_n,
    mb_reduce_engine_if.master bus
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StWaitLo = 3'd2;
    localparam logic [2:0] StWaitHi = 3'd3;
    localparam logic [2:0] StEmit   = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam logic [13:0] LastBlock = 14'h3FFF;

    logic [2:0]  state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [7:0]  res_q, res_d;
    logic        dr_prev_q;

    logic [7:0] p0, p1, p2, p3;
    logic [9:0] sum;
    logic [7:0] avg, max01, max23, max_all, reduced;

    assign p0 = bus.MB_flat[7:0];
    assign p1 = bus.MB_flat[15:8];
    assign p2 = bus.MB_flat[23:16];
    assign p3 = bus.MB_flat[31:24];

    // 10-bit sum cannot overflow (4*255+2 = 1022), so the shifted result fits 8 bits.
    assign sum     = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + 10'd2;
    assign avg     = 8'(sum >> 2);
    assign max01   = (p0 > p1) ? p0 : p1;
    assign max23   = (p2 > p3) ? p2 : p3;
    assign max_all = (max01 > max23) ? max01 : max23;
    assign reduced = mode_q ? max_all : avg;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                // Edge-triggered start: a level held across reset does not count.
                if (bus.data_ready && !dr_prev_q) begin
                    state_d = StIssue;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                end
            end
            StIssue: state_d = StWaitLo;
            StWaitLo: begin
                if (!bus.MB_ready) state_d = StWaitHi;
            end
            StWaitHi: begin
                if (bus.MB_ready) begin
                    res_d   = reduced;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (!bus.res_full) begin
                    if (cnt_q == LastBlock) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 14'd1;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                if (!bus.data_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            res_q     <= '0;
            dr_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            res_q     <= res_d;
            dr_prev_q <= bus.data_ready;
        end
    end

    // Counter only moves on a transfer, so the address holds from ISSUE to the next ISSUE.
    assign bus.inq_addr       = {1'b0, cnt_q};
    assign bus.inqury_update  = (state_q == StIssue);
    assign bus.frame_complete = (state_q != StIdle) && (cnt_q == LastBlock);
    assign bus.res_data       = res_q;
    assign bus.res_valid      = (state_q == StEmit);
    assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_mb_reduce_engine.sv
module tb_mb_reduce_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mb_reduce_engine_if bus ();

    mb_reduce_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [16384];
    int  mem_lat   = 3;
    bit  exp_mode  = 1'b0;
    bit  rand_bp   = 1'b0;
    int  stall_req = 0;

    int          req_cyc[$];
    logic [7:0]  outs[$];
    int          stall_runs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference reduction computed from the pixel values with plain integers.
    function automatic logic [7:0] ref_reduce(input logic [31:0] w, input bit m);
        int s  = 0;
        int mx = 0;
        for (int i = 0; i < 4; i++) begin
            int b = int'((w >> (8 * i)) & 32'hFF);
            s += b;
            if (b > mx) mx = b;
        end
        return m ? mx[7:0] : 8'((s + 2) / 4);
    endfunction

    // Memory interface model: MB_ready low after a request, data valid when it rises.
    int          low = 0;
    logic [13:0] pend_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            low          = 0;
            bus.MB_ready = 1'b1;
            bus.MB_flat  = 32'h0;
        end else begin
            if (low > 0) begin
                low--;
                if (low == 0) begin
                    bus.MB_ready = 1'b1;
                    bus.MB_flat  = mem[pend_addr];
                end
            end
            if (bus.inqury_update) begin
                pend_addr    = bus.inq_addr[13:0];
                bus.MB_ready = 1'b0;
                bus.MB_flat  = $urandom;
                low          = mem_lat;
            end
        end
    end

    // Byte sink, backpressure source and stream checker.
    int         exp_req    = 0;
    int         exp_xfer   = 0;
    bit         prev_hold  = 1'b0;
    logic [7:0] prev_data  = '0;
    int         run        = 0;
    int         stall_left = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.res_full = 1'b0;
            stall_left   = 0;
            exp_req      = 0;
            exp_xfer     = 0;
            prev_hold    = 1'b0;
            run          = 0;
        end else begin
            if (stall_left == 0 && stall_req > 0 && bus.res_valid) begin
                stall_left = stall_req;
                stall_req  = 0;
            end
            if (stall_left > 0) begin
                bus.res_full = 1'b1;
                stall_left--;
            end else begin
                bus.res_full = rand_bp && ($urandom_range(0, 3) == 0);
            end
            if (prev_hold) begin
                chk("hold_valid", bus.res_valid, 1);
                chk("hold_data", bus.res_data, prev_data);
                chk("stall_noreq", bus.inqury_update, 0);
            end
            if (bus.inqury_update) begin
                chk("req_addr", bus.inq_addr, exp_req);
                chk("req_fc", bus.frame_complete, exp_req == 16383);
                req_cyc.push_back(cyc);
                exp_req++;
            end
            if (bus.res_valid && !bus.res_full) begin
                chk("xfer_data", bus.res_data, ref_reduce(mem[exp_xfer % 16384], exp_mode));
                chk("xfer_addr", bus.inq_addr, exp_xfer);
                outs.push_back(bus.res_data);
                exp_xfer++;
            end
            if (bus.res_valid && bus.res_full) begin
                run++;
            end else if (run > 0) begin
                stall_runs.push_back(run);
                run = 0;
            end
            prev_hold = bus.res_valid && bus.res_full;
            prev_data = bus.res_data;
        end
    end

    task automatic wait_xfers(input int n, input int budget);
        int k = 0;
        while (outs.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_xfers", outs.size() >= n, 1);
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int k = 0;
        while (req_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_reqs", req_cyc.size() >= n, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_addr"}, bus.inq_addr, 0);
        chk({tag, "_req"}, bus.inqury_update, 0);
        chk({tag, "_fc"}, bus.frame_complete, 0);
        chk({tag, "_valid"}, bus.res_valid, 0);
        chk({tag, "_data"}, bus.res_data, 0);
    endtask

    task automatic clear_logs();
        outs.delete();
        req_cyc.delete();
        stall_runs.delete();
    endtask

    task automatic start_frame(input bit m);
        @(posedge clk);
        #1 bus.data_ready = 1'b0;
        bus.mode = m;
        exp_mode = m;
        repeat (2) @(posedge clk);
        #1 bus.data_ready = 1'b1;
    endtask

    task automatic abort();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[16383] = 32'hFFFF_FFFF;
        bus.data_ready = 1'b1;
        bus.mode       = 1'b1;

        // Reset with data_ready already high: outputs cleared, no frame start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("level_nostart_req", req_cyc.size(), 0);
        chk("level_nostart_busy", bus.busy, 0);

        // Average mode, no backpressure, realistic memory latency.
        mem[0] = 32'h0403_0201;
        mem[1] = 32'hFFFF_FFFF;
        start_frame(1'b0);
        wait_xfers(3, 100);
        chk("avg_blk0", outs[0], 8'h03);
        chk("avg_ff", outs[1], 8'hFF);
        chk("spacing_01", req_cyc[1] - req_cyc[0], 5);
        chk("spacing_12", req_cyc[2] - req_cyc[1], 5);

        // Seven-cycle stall on block 5.
        wait_xfers(5, 100);
        stall_req = 7;
        wait_xfers(7, 200);
        chk("stall_runs", stall_runs.size(), 1);
        chk("stall_len", stall_runs[0], 7);
        chk("stall_spacing", req_cyc[6] - req_cyc[5], 12);

        // data_ready falls and rises again mid-frame: both ignored.
        wait_reqs(50, 500);
        #1 bus.data_ready = 1'b0;
        wait_reqs(60, 200);
        #1 bus.data_ready = 1'b1;
        wait_reqs(101, 500);
        chk("midframe_busy", bus.busy, 1);

        // Reset during block 100.
        @(posedge clk);
        abort();
        check_reset_outs("abort");
        chk("abort_xfers", outs.size(), 100);
        clear_logs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_level_nostart", req_cyc.size(), 0);

        // Max mode with random backpressure; mode change after start is ignored.
        mem[0]  = 32'h10FF_2080;
        rand_bp = 1'b1;
        start_frame(1'b1);
        @(posedge clk);
        #1 bus.mode = 1'b0;
        wait_xfers(40, 1000);
        chk("max_blk0", outs[0], 8'hFF);
        chk("max_first_addr", req_cyc.size() > 0, 1);
        abort();
        check_reset_outs("abort2");
        rand_bp = 1'b0;
        clear_logs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full frame with a faster memory.
        mem_lat = 2;
        start_frame(1'b0);
        wait_xfers(16384, 70000);
        repeat (3) @(negedge clk);
        chk("frame_xfers", outs.size(), 16384);
        chk("frame_reqs", req_cyc.size(), 16384);
        chk("done_busy", bus.busy, 1);
        chk("done_fc", bus.frame_complete, 1);
        chk("done_valid", bus.res_valid, 0);
        chk("done_addr", bus.inq_addr, 15'h3FFF);
        chk("last_byte", outs[16383], 8'hFF);
        repeat (5) @(negedge clk);
        chk("done_hold_busy", bus.busy, 1);
        chk("done_hold_reqs", req_cyc.size(), 16384);
        @(posedge clk);
        #1 bus.data_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_fc", bus.frame_complete, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mb_reduce_engine.md
MB_REDUCE_ENGINE -- requirements
Module: mb_reduce_engine

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock shared with the memory interface.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-003 SHALL have port: data_ready  input  1  frame fully written to the four-bank DRAM.
REQ-004 SHALL have port: MB_flat  input  32  2x2 macroblock {p3,p2,p1,p0}, byte p0 in [7:0].
REQ-005 SHALL have port: MB_ready  input  1  memory interface idle / MB_flat valid.
REQ-006 SHALL have port: inq_addr  output  15  macroblock address; bit 14 always 0; [13:7]=row, [6:0]=col.
REQ-007 SHALL have port: inqury_update  output  1  one-cycle read request to the memory interface.
REQ-008 SHALL have port: frame_complete  output  1  marks the final request and the finished frame.
REQ-009 SHALL have port: mode  input  1  0 = rounded average, 1 = maximum; sampled at frame start only.
REQ-010 SHALL have port: res_data  output  8  reduced pixel.
REQ-011 SHALL have port: res_valid  output  1  res_data valid.
REQ-012 SHALL have port: res_full  input  1  downstream byte sink cannot accept.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_LO, WAIT_HI, EMIT, DONE.
REQ-015 IDLE SHALL move to ISSUE on a rising edge of data_ready (registered previous value 0, current 1), latching mode and clearing the 14-bit block counter to 0.
REQ-016 A data_ready level already high at reset release SHALL NOT start a frame.
REQ-017 ISSUE SHALL drive inqury_update=1 for exactly one cycle with inq_addr={1'b0,counter} and then go to WAIT_LO.
REQ-018 When counter==16383, frame_complete SHALL be 1 in the same cycle as inqury_update and SHALL stay 1 until DONE exits.
REQ-019 WAIT_LO SHALL go to WAIT_HI when it samples MB_ready==0.
REQ-020 WAIT_HI SHALL capture MB_flat and go to EMIT when it samples MB_ready==1.
REQ-021 With the current memory interface, MB_flat SHALL be captured on the 3rd rising edge after the request edge.
REQ-022 inq_addr SHALL remain stable from ISSUE until the next ISSUE.
REQ-023 Average mode: 10-bit sum p0+p1+p2+p3+2, right-shifted by 2; the result SHALL NOT overflow 8 bits (255,255,255,255 -> 255).
REQ-024 Max mode: unsigned maximum of the four bytes.
REQ-025 EMIT SHALL drive res_valid=1 with res_data stable until a cycle in which res_full==0; that edge is the transfer.
REQ-026 res_valid SHALL drop on the cycle after the transfer.
REQ-027 After a transfer with counter<16383, the counter SHALL increment and the state SHALL go to ISSUE.
REQ-028 After a transfer with counter==16383, the state SHALL go to DONE.
REQ-029 Throughput without backpressure: 5 cycles per block.
REQ-030 Output order SHALL be raster: col fastest; the column counter SHALL wrap 127->0 while the row increments.
REQ-031 DONE SHALL hold frame_complete=1 and busy=1 until data_ready==0, then go to IDLE with frame_complete=0.
REQ-032 data_ready falling mid-frame SHALL be ignored; the frame SHALL run to completion.
REQ-033 A data_ready rising edge while not in IDLE SHALL be ignored.
REQ-034 res_full asserted for any duration SHALL stall in EMIT without losing or duplicating a byte; no new inqury_update is issued while stalled.

Reset
REQ-035 While rst_n==0 at a clk edge: state=IDLE, counter=0, inq_addr=0, inqury_update=0, frame_complete=0, res_valid=0, res_data=0, busy=0, latched mode=0, data_ready history=1.
REQ-036 Reset asserted mid-frame SHALL abort immediately with the outputs of REQ-035 on the next cycle; no partial byte SHALL be transferred.

Verification
REQ-037 Avg, no backpressure: data_ready rises; block 0 MB_flat=0x04030201 -> res_data=0x03; inq_addr steps 0,1,2 at 5-cycle spacing.
REQ-038 Max mode: MB_flat=0x10FF2080 -> res_data=0xFF; MB_flat=0xFFFFFFFF in avg mode -> 0xFF.
REQ-039 Backpressure: res_full=1 for 7 cycles in EMIT -> res_valid and res_data held 7 cycles, one transfer, next inqury_update only after it.
REQ-040 Full frame: 16384 transfers; frame_complete rises with inqury_update at inq_addr=0x3FFF; busy holds until data_ready falls; then IDLE.
REQ-041 Reset at block 100 -> next cycle outputs match REQ-035; a fresh data_ready edge restarts at inq_addr=0.
REQ-042 Level start: data_ready high before rst_n release -> no inqury_update until data_ready falls and rises again.
